// File: rtl/ps2_scan_filter_pkg.sv
// Shared constants, FSM states and FIFO entry width for the PS/2 scan filter.
// Entry width depends on the PS2_SHIFT_TRACK_EN macro (adds a shift bit).
package ps2_scan_filter_pkg;

  localparam logic [7:0] BRK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE = 8'hE0;
  localparam logic [7:0] LSHIFT   = 8'h12;
  localparam logic [7:0] RSHIFT   = 8'h59;

`ifdef PS2_SHIFT_TRACK_EN
  // Entry layout: {shift, ext, code[7:0]}
  localparam int ENTRY_W = 10;
`else
  // Entry layout: {ext, code[7:0]}
  localparam int ENTRY_W = 9;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXT  = 2'd1,
    ST_BRK  = 2'd2
  } filt_state_t;

  function automatic logic is_shift_code(input logic [7:0] code);
    return (code == LSHIFT) || (code == RSHIFT);
  endfunction

endpackage

// File: rtl/ps2_scan_filter_key_fifo.sv
// First-word-fall-through FIFO holding decoded key entries.
// Full/empty are registered flags; a push while full is accepted only with a
// simultaneous pop, and a pop while empty is ignored.
module key_fifo #(
  parameter int WIDTH  = 9,
  parameter int W_SIZE = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_full
);

  logic [WIDTH-1:0]  r_mem [2**W_SIZE];
  logic [W_SIZE-1:0] r_wptr;
  logic [W_SIZE-1:0] r_rptr;
  logic              r_empty;
  logic              r_full;
  logic              w_do_push;
  logic              w_do_pop;
  logic [W_SIZE-1:0] w_wptr_nxt;
  logic [W_SIZE-1:0] w_rptr_nxt;

  assign w_do_pop   = i_pop && !r_empty;
  assign w_do_push  = i_push && (!r_full || w_do_pop);
  assign w_wptr_nxt = r_wptr + 1'b1;
  assign w_rptr_nxt = r_rptr + 1'b1;

  assign o_rdata = r_mem[r_rptr];
  assign o_empty = r_empty;
  assign o_full  = r_full;

  // Storage array write; contents need no reset since flags gate visibility.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  // Pointer and status-flag update; flags only change when occupancy changes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_wptr <= w_wptr_nxt;
      end
      if (w_do_pop) begin
        r_rptr <= w_rptr_nxt;
      end
      if (w_do_push && !w_do_pop) begin
        r_empty <= 1'b0;
        r_full  <= (w_wptr_nxt == r_rptr);
      end else if (w_do_pop && !w_do_push) begin
        r_full  <= 1'b0;
        r_empty <= (w_rptr_nxt == r_wptr);
      end
    end
  end

endmodule

// File: rtl/ps2_scan_filter.sv
// PS/2 scan-code filter: strips break (F0 xx) and extended (E0) prefixes,
// tags extended keys and queues make codes in a small FWFT FIFO.
// Optional Shift tracking is enabled by defining PS2_SHIFT_TRACK_EN.
module ps2_scan_filter
  import ps2_scan_filter_pkg::*;
#(
  parameter int W_SIZE = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  input  logic       rd_key,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_shift,
  output logic       key_empty,
  output logic       key_full,
  output logic       drop_tick
);

  filt_state_t        r_state;
  filt_state_t        w_state_nxt;
  logic               r_ext;
  logic               w_ext_nxt;
  logic               r_drop;
  logic               w_push;
  logic [ENTRY_W-1:0] w_wdata;
  logic [ENTRY_W-1:0] w_rdata;
  logic               w_empty;
  logic               w_full;
`ifdef PS2_SHIFT_TRACK_EN
  logic               r_shift;
  logic               w_shift_nxt;
`endif

  // Filter FSM state, extended flag, shift flag and drop pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_ext   <= 1'b0;
      r_drop  <= 1'b0;
`ifdef PS2_SHIFT_TRACK_EN
      r_shift <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_ext   <= w_ext_nxt;
      r_drop  <= w_push && w_full && !rd_key;
`ifdef PS2_SHIFT_TRACK_EN
      r_shift <= w_shift_nxt;
`endif
    end
  end

  // Next-state decode; a make code raises w_push with the entry to store.
  always_comb begin
    w_state_nxt = r_state;
    w_ext_nxt   = r_ext;
    w_push      = 1'b0;
`ifdef PS2_SHIFT_TRACK_EN
    w_shift_nxt = r_shift;
    w_wdata     = {r_shift, 1'b0, rx_data};
`else
    w_wdata     = {1'b0, rx_data};
`endif
    if (rx_done_tick) begin
      unique case (r_state)
        ST_IDLE: begin
          if (rx_data == BRK_CODE) begin
            w_state_nxt = ST_BRK;
          end else if (rx_data == EXT_CODE) begin
            w_state_nxt = ST_EXT;
            w_ext_nxt   = 1'b1;
`ifdef PS2_SHIFT_TRACK_EN
          end else if (is_shift_code(rx_data)) begin
            w_shift_nxt = 1'b1;
`endif
          end else begin
            w_push = 1'b1;
          end
        end
        ST_EXT: begin
          if (rx_data == BRK_CODE) begin
            w_state_nxt = ST_BRK;
          end else if (rx_data != EXT_CODE) begin
            w_push      = 1'b1;
`ifdef PS2_SHIFT_TRACK_EN
            w_wdata     = {r_shift, 1'b1, rx_data};
`else
            w_wdata     = {1'b1, rx_data};
`endif
            w_ext_nxt   = 1'b0;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_BRK: begin
`ifdef PS2_SHIFT_TRACK_EN
          if (!r_ext && is_shift_code(rx_data)) begin
            w_shift_nxt = 1'b0;
          end
`endif
          w_ext_nxt   = 1'b0;
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_ext_nxt   = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  key_fifo #(
    .WIDTH  (ENTRY_W),
    .W_SIZE (W_SIZE)
  ) u_key_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_pop   (rd_key),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign key_code  = w_empty ? 8'h00 : w_rdata[7:0];
  assign key_ext   = w_empty ? 1'b0  : w_rdata[8];
`ifdef PS2_SHIFT_TRACK_EN
  assign key_shift = w_empty ? 1'b0  : w_rdata[9];
`else
  assign key_shift = 1'b0;
`endif
  assign key_empty = w_empty;
  assign key_full  = w_full;
  assign drop_tick = r_drop;

endmodule

// File: tb/tb_ps2_scan_filter.sv
// Self-checking bench for ps2_scan_filter: a table of single-cycle vectors
// plus hand-written sequences for reset-after-break and Shift tracking
// (PS2_SHIFT_TRACK_EN selects the expected Shift behaviour).
module tb_ps2_scan_filter;

  logic       clk;
  logic       reset_n;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic       rd_key;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_shift;
  logic       key_empty;
  logic       key_full;
  logic       drop_tick;

  int errCount;
  int checkCount;

  typedef struct {
    logic       tick;
    logic [7:0] data;
    logic       rd;
    logic       expEmpty;
    logic       expFull;
    logic [7:0] expCode;
    logic       expExt;
    logic       expDrop;
  } vec_t;

  vec_t vecs [25];

  ps2_scan_filter #(.W_SIZE(2)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .rd_key       (rd_key),
    .key_code     (key_code),
    .key_ext      (key_ext),
    .key_shift    (key_shift),
    .key_empty    (key_empty),
    .key_full     (key_full),
    .drop_tick    (drop_tick)
  );

  // Free-running 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one cycle of inputs, then samples 1 time unit after the edge
  task automatic applyStimulus(input logic tick, input logic [7:0] data, input logic rd);
    rx_done_tick = tick;
    rx_data      = data;
    rd_key       = rd;
    @(posedge clk);
    #1;
    rx_done_tick = 1'b0;
    rx_data      = 8'h00;
    rd_key       = 1'b0;
  endtask

  // Compares all outputs as one packed word {empty,full,code,ext,shift,drop}
  task automatic checkOutput(input string name, input logic expEmpty, input logic expFull,
                             input logic [7:0] expCode, input logic expExt,
                             input logic expShift, input logic expDrop);
    logic [12:0] act;
    logic [12:0] exp;
    act = {key_empty, key_full, key_code, key_ext, key_shift, drop_tick};
    exp = {expEmpty, expFull, expCode, expExt, expShift, expDrop};
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got empty=%b full=%b code=%h ext=%b shift=%b drop=%b, want empty=%b full=%b code=%h ext=%b shift=%b drop=%b",
               name, act[12], act[11], act[10:3], act[2], act[1], act[0],
               exp[12], exp[11], exp[10:3], exp[2], exp[1], exp[0]);
    end
  endtask

  initial begin
    errCount     = 0;
    checkCount   = 0;
    reset_n      = 1'b0;
    rx_done_tick = 1'b0;
    rx_data      = 8'h00;
    rd_key       = 1'b0;

    // tick, data, rd, empty, full, code, ext, drop
    vecs[0]  = '{1'b1, 8'h1C, 1'b0, 1'b0, 1'b0, 8'h1C, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'hF0, 1'b0, 1'b0, 1'b0, 8'h1C, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 8'h1C, 1'b0, 1'b0, 1'b0, 8'h1C, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 8'hE0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 8'h75, 1'b0, 1'b0, 1'b0, 8'h75, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 8'hE0, 1'b0, 1'b0, 1'b0, 8'h75, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 8'hF0, 1'b0, 1'b0, 1'b0, 8'h75, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 8'h75, 1'b0, 1'b0, 1'b0, 8'h75, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 8'h16, 1'b0, 1'b0, 1'b0, 8'h16, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 8'h1E, 1'b0, 1'b0, 1'b0, 8'h16, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 8'h26, 1'b0, 1'b0, 1'b0, 8'h16, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 8'h25, 1'b0, 1'b0, 1'b1, 8'h16, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 8'h2E, 1'b0, 1'b0, 1'b1, 8'h16, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h16, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 8'h36, 1'b1, 1'b0, 1'b1, 8'h1E, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h26, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h25, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h36, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[21] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[22] = '{1'b1, 8'h4D, 1'b1, 1'b0, 1'b0, 8'h4D, 1'b0, 1'b0};
    vecs[23] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[24] = '{1'b0, 8'h1C, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 25; i++) begin
      applyStimulus(vecs[i].tick, vecs[i].data, vecs[i].rd);
      checkOutput($sformatf("vec%0d", i), vecs[i].expEmpty, vecs[i].expFull,
                  vecs[i].expCode, vecs[i].expExt, 1'b0, vecs[i].expDrop);
    end

    // Reset after F0 must discard break state so 1C is pushed as a make
    applyStimulus(1'b1, 8'hF0, 1'b0);
    reset_n = 1'b0;
    #2;
    checkOutput("midreset_low", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 8'h1C, 1'b0);
    checkOutput("midreset_make", 1'b0, 1'b0, 8'h1C, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("midreset_pop", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Shift sequence: 12, 1C, F0, 1C, F0, 12, 1C
    applyStimulus(1'b1, 8'h12, 1'b0);
    applyStimulus(1'b1, 8'h1C, 1'b0);
    applyStimulus(1'b1, 8'hF0, 1'b0);
    applyStimulus(1'b1, 8'h1C, 1'b0);
    applyStimulus(1'b1, 8'hF0, 1'b0);
    applyStimulus(1'b1, 8'h12, 1'b0);
    applyStimulus(1'b1, 8'h1C, 1'b0);
`ifdef PS2_SHIFT_TRACK_EN
    checkOutput("shift_head1", 1'b0, 1'b0, 8'h1C, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("shift_head2", 1'b0, 1'b0, 8'h1C, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("shift_drained", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
`else
    checkOutput("noshift_head1", 1'b0, 1'b0, 8'h12, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("noshift_head2", 1'b0, 1'b0, 8'h1C, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("noshift_head3", 1'b0, 1'b0, 8'h1C, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("noshift_drained", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
